// File: rtl/spike_packet_dispatcher_if.sv
// Handshake bundle between the token controller, the dispatcher queue and the router.
// The master modport is the dispatcher's view; slave is the surrounding environment.
interface spike_packet_dispatcher_if #(
  parameter int PACKET_WIDTH = 30
);
  logic                    spike_in;
  logic [PACKET_WIDTH-1:0] packet_in;
  logic                    local_buffers_full;
  logic [PACKET_WIDTH-1:0] packet_out;
  logic                    packet_valid;
  logic                    packet_ready;

  modport master (
    input  spike_in, packet_in, packet_ready,
    output packet_out, packet_valid, local_buffers_full
  );

  modport slave (
    output spike_in, packet_in, packet_ready,
    input  packet_out, packet_valid, local_buffers_full
  );
endinterface

// File: rtl/spike_packet_dispatcher.sv
// Outgoing spike packet queue: circular FIFO between token controller and router.
// Optional macro SPIKE_DROP_COUNT_EN adds a saturating 16-bit drop_count output.
module spike_packet_dispatcher #(
  parameter int PACKET_WIDTH = 30,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  spike_packet_dispatcher_if.master bus,
  output logic error,
  output logic tick_overrun
`ifdef SPIKE_DROP_COUNT_EN
  ,
  output logic [15:0] drop_count
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  logic [PACKET_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr;
  logic [PW:0]             count;
  logic                    full;
  logic                    pop;
  logic                    push;
  logic                    drop;

  assign full = (count == DEPTH_C);
  assign pop  = bus.packet_valid && bus.packet_ready;
  // A pop in the same edge frees a slot, so a full queue still accepts the spike.
  assign push = bus.spike_in && (!full || pop);
  assign drop = bus.spike_in && full && !pop;

  assign bus.packet_valid       = (count != '0);
  assign bus.packet_out         = mem[rd_ptr];
  assign bus.local_buffers_full = (count >= DEPTH_C - 1'b1);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.packet_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      error        <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        error <= 1'b1;
      end
      if (tick && (count != '0)) begin
        tick_overrun <= 1'b1;
      end
    end
  end

`ifdef SPIKE_DROP_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spike_packet_dispatcher.sv
// Directed bench for spike_packet_dispatcher with a queue-level reference model.
module tb_spike_packet_dispatcher;
  logic clk;
  logic rst;
  logic tick;
  logic error;
  logic tick_overrun;
`ifdef SPIKE_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  int total = 0;
  int bad   = 0;

  spike_packet_dispatcher_if #(.PACKET_WIDTH(30)) bus();

  spike_packet_dispatcher #(.PACKET_WIDTH(30), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .bus          (bus),
    .error        (error),
    .tick_overrun (tick_overrun)
`ifdef SPIKE_DROP_COUNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue plus the sticky flags.
  logic [29:0] mq[$];
  bit          m_err;
  bit          m_ovr;
  int          m_drops;

  task automatic model_clear();
    mq.delete();
    m_err   = 1'b0;
    m_ovr   = 1'b0;
    m_drops = 0;
  endtask

  always @(posedge rst) model_clear();

  always @(posedge clk) begin
    if (rst) begin
      model_clear();
    end else begin
      int  n;
      bit  pop;
      bit  full;
      n    = mq.size();
      pop  = (n != 0) && bus.packet_ready;
      full = (n == 4);
      if (tick && n != 0) m_ovr = 1'b1;
      if (pop) void'(mq.pop_front());
      if (bus.spike_in) begin
        if (!full || pop) mq.push_back(bus.packet_in);
        else begin
          m_err = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("rst_valid", 32'(bus.packet_valid), 32'd0);
      check("rst_lbf", 32'(bus.local_buffers_full), 32'd0);
    end else begin
      check("valid", 32'(bus.packet_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) check("out", 32'(bus.packet_out), 32'(mq[0]));
      check("lbf", 32'(bus.local_buffers_full), 32'(mq.size() >= 3));
      check("error", 32'(error), 32'(m_err));
      check("overrun", 32'(tick_overrun), 32'(m_ovr));
`ifdef SPIKE_DROP_COUNT_EN
      check("drop_count", 32'(drop_count), 32'(m_drops));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [29:0] p);
    bus.spike_in  = 1'b1;
    bus.packet_in = p;
    step();
    bus.spike_in  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [29:0] ord[4];

  initial begin
    rst              = 1'b1;
    tick             = 1'b0;
    bus.spike_in     = 1'b0;
    bus.packet_in    = '0;
    bus.packet_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset_valid", 32'(bus.packet_valid), 32'd0);
    check("reset_lbf", 32'(bus.local_buffers_full), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_overrun", 32'(tick_overrun), 32'd0);

    // single pass through an empty queue
    bus.packet_ready = 1'b1;
    push(30'h1234567);
    check("single_valid", 32'(bus.packet_valid), 32'd1);
    check("single_out", 32'(bus.packet_out), 32'h1234567);
    step();
    check("single_drained", 32'(bus.packet_valid), 32'd0);

    // fill, then overfill by one
    bus.packet_ready = 1'b0;
    push(30'h0000A0A);
    check("fill_head", 32'(bus.packet_out), 32'h0000A0A);
    push(30'h0000B0B);
    check("fill_lbf_at2", 32'(bus.local_buffers_full), 32'd0);
    push(30'h0000C0C);
    check("fill_lbf_at3", 32'(bus.local_buffers_full), 32'd1);
    push(30'h0000D0D);
    check("d_stored_error", 32'(error), 32'd0);
    push(30'h0000E0E);
    check("e_dropped_error", 32'(error), 32'd1);
    check("stable_head", 32'(bus.packet_out), 32'h0000A0A);
`ifdef SPIKE_DROP_COUNT_EN
    check("drop_count_one", 32'(drop_count), 32'd1);
`endif

    // drain order
    ord[0] = 30'h0000A0A; ord[1] = 30'h0000B0B; ord[2] = 30'h0000C0C; ord[3] = 30'h0000D0D;
    bus.packet_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("order_out", 32'(bus.packet_out), 32'(ord[i]));
      step();
    end
    check("order_empty", 32'(bus.packet_valid), 32'd0);

    // push and pop together on a full queue
    do_reset();
    check("reset_clears_error", 32'(error), 32'd0);
    bus.packet_ready = 1'b0;
    push(30'h0000111);
    push(30'h0000222);
    push(30'h0000333);
    push(30'h0000444);
    bus.packet_ready = 1'b1;
    push(30'h0000555);
    bus.packet_ready = 1'b0;
    check("simul_lbf", 32'(bus.local_buffers_full), 32'd1);
    check("simul_head", 32'(bus.packet_out), 32'h0000222);
    check("simul_error", 32'(error), 32'd0);
    ord[0] = 30'h0000222; ord[1] = 30'h0000333; ord[2] = 30'h0000444; ord[3] = 30'h0000555;
    bus.packet_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("simul_order", 32'(bus.packet_out), 32'(ord[i]));
      step();
    end
    check("simul_empty", 32'(bus.packet_valid), 32'd0);

    // tick on empty, tick with two entries, then mid-cycle reset
    bus.packet_ready = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("tick_empty_overrun", 32'(tick_overrun), 32'd0);
    push(30'h3FFFFFF);
    push(30'h0000777);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("tick_overrun", 32'(tick_overrun), 32'd1);
    check("tick_keeps_head", 32'(bus.packet_out), 32'h3FFFFFF);
    push(30'h0000888);
    push(30'h0000999);
    push(30'h0000AAA);
    check("tick_drop_error", 32'(error), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_valid", 32'(bus.packet_valid), 32'd0);
    check("async_error", 32'(error), 32'd0);
    check("async_overrun", 32'(tick_overrun), 32'd0);
    check("async_lbf", 32'(bus.local_buffers_full), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_reset_valid", 32'(bus.packet_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
